// File: rtl/ir_sched_pkg.sv
// Shared types and constants for the AC IR command scheduler.
package ir_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        GAP
    } state_t;

    localparam int IR_W35 = 35;
    localparam int IR_W32 = 32;

    // 100 MHz core: 40 ms gap, 250 ms transmit watchdog
    localparam int DEF_NUM_REQ        = 3;
    localparam int DEF_REPEAT         = 1;
    localparam int DEF_GAP_CYCLES     = 4000000;
    localparam int DEF_TIMEOUT_CYCLES = 25000000;

    localparam logic [IR_W35-1:0] PWR_OFF_35 = 35'b10000010000100000000010000001010010;
    localparam logic [IR_W32-1:0] PWR_OFF_32 = 32'b00001000000001000000000000000110;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ir_rr_arbiter.sv
// Combinational round-robin pick: first asserted valid at or above rr_ptr, wrapping mod NUM_REQ.
module ir_rr_arbiter
    import ir_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = cnt_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               grant_any
);

    int k;

    always_comb begin
        grant     = '0;
        idx       = '0;
        grant_any = 1'b0;
        k         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (!grant_any && valid[k]) begin
                grant_any = 1'b1;
                grant[k]  = 1'b1;
                idx       = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/ir_cmd_scheduler.sv
// Round-robin AC IR command scheduler: launch, watchdog, repeat and inter-frame gap.
// Build option IR_SCHED_DEDUP_EN drops a request identical to the last successfully sent frame.
module ir_cmd_scheduler
    import ir_sched_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int REPEAT         = DEF_REPEAT,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*IR_W35-1:0] req_data35,
    input  logic [NUM_REQ*IR_W32-1:0] req_data32,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [IR_W35-1:0]         tx_data35,
    output logic [IR_W32-1:0]         tx_data32,
    input  logic                      tx_busy,
    input  logic                      tx_done,
    output logic                      busy,
    output logic                      err_timeout,
    output logic [15:0]               frame_cnt
);

    localparam int IDX_W = cnt_width(NUM_REQ);
    localparam int GAP_W = cnt_width(GAP_CYCLES + 1);
    localparam int WD_W  = cnt_width(TIMEOUT_CYCLES);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   arb_idx;
    logic [NUM_REQ-1:0] arb_grant;
    logic               arb_any;
    logic [3:0]         rep_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [WD_W-1:0]    wdog;
    logic               timed_out;
    logic [IR_W35-1:0]  sel35;
    logic [IR_W32-1:0]  sel32;
    logic               dup_hit;
    logic               accept;
    logic               tmo;
    logic               gap_end;
    logic               more;
    logic               finish;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    ir_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .valid     (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (arb_grant),
        .idx       (arb_idx),
        .grant_any (arb_any)
    );

    assign sel35 = req_data35[int'(arb_idx)*IR_W35 +: IR_W35];
    assign sel32 = req_data32[int'(arb_idx)*IR_W32 +: IR_W32];

`ifdef IR_SCHED_DEDUP_EN
    logic              last_vld;
    logic [IR_W35-1:0] last35;
    logic [IR_W32-1:0] last32;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_vld <= 1'b0;
            last35   <= '0;
            last32   <= '0;
        end else if (finish && !timed_out) begin
            last_vld <= 1'b1;
            last35   <= tx_data35;
            last32   <= tx_data32;
        end
    end

    assign dup_hit = last_vld && (sel35 == last35) && (sel32 == last32);
`else
    assign dup_hit = 1'b0;
`endif

    // A timed-out command abandons its remaining repeats.
    assign more   = !timed_out && (int'(rep_cnt) < REPEAT - 1);
    assign finish = gap_end && !more;
    assign busy   = (state != IDLE);

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        tx_start  = 1'b0;
        accept    = 1'b0;
        tmo       = 1'b0;
        gap_end   = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    req_ready = arb_grant;
                    accept    = 1'b1;
                    state_nxt = dup_hit ? IDLE : LAUNCH;
                end
            end
            LAUNCH: begin
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // done has priority over a watchdog expiring in the same cycle
                if (tx_done) begin
                    state_nxt = GAP;
                end else if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo       = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_cnt <= GAP_W'(1)) begin
                    gap_end   = 1'b1;
                    state_nxt = more ? LAUNCH : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            win_idx     <= '0;
            rep_cnt     <= '0;
            gap_cnt     <= '0;
            wdog        <= '0;
            timed_out   <= 1'b0;
            err_timeout <= 1'b0;
            frame_cnt   <= '0;
            tx_data35   <= '0;
            tx_data32   <= '0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                tx_data35 <= sel35;
                tx_data32 <= sel32;
                win_idx   <= arb_idx;
                rep_cnt   <= '0;
                timed_out <= 1'b0;
                if (dup_hit) begin
                    rr_ptr <= next_idx(arb_idx);
                end
            end

            if (tx_start) begin
                wdog <= '0;
            end else if (state == WAIT_DONE) begin
                wdog <= wdog + 1'b1;
            end

            if (state == WAIT_DONE && state_nxt == GAP) begin
                gap_cnt <= GAP_W'(GAP_CYCLES);
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - 1'b1;
            end

            if (tmo) begin
                timed_out   <= 1'b1;
                err_timeout <= 1'b1;
            end

            if (gap_end && more) begin
                rep_cnt <= rep_cnt + 4'd1;
            end

            if (finish) begin
                rr_ptr <= next_idx(win_idx);
                if (!timed_out) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// Directed bench for ir_cmd_scheduler: u1 runs REPEAT=1, u3 runs REPEAT=3, both GAP=10, TIMEOUT=50.
module tb_ir_cmd_scheduler;
    import ir_sched_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req_valid;
    logic [104:0]  req_data35;
    logic [95:0]   req_data32;
    logic          tx_busy;
    logic          tx_done;

    logic [2:0]    rdy1, rdy3;
    logic          start1, start3;
    logic [34:0]   d35_1, d35_3;
    logic [31:0]   d32_1, d32_3;
    logic          busy1, busy3;
    logic          err1, err3;
    logic [15:0]   fc1, fc3;

    logic [34:0]   s35 [3];
    logic [31:0]   s32 [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ir_cmd_scheduler #(.NUM_REQ(3), .REPEAT(1), .GAP_CYCLES(10), .TIMEOUT_CYCLES(50)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data35(req_data35),
        .req_data32(req_data32), .req_ready(rdy1), .tx_start(start1), .tx_data35(d35_1),
        .tx_data32(d32_1), .tx_busy(tx_busy), .tx_done(tx_done), .busy(busy1),
        .err_timeout(err1), .frame_cnt(fc1)
    );

    ir_cmd_scheduler #(.NUM_REQ(3), .REPEAT(3), .GAP_CYCLES(10), .TIMEOUT_CYCLES(50)) u3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data35(req_data35),
        .req_data32(req_data32), .req_ready(rdy3), .tx_start(start3), .tx_data35(d35_3),
        .tx_data32(d32_3), .tx_busy(tx_busy), .tx_done(tx_done), .busy(busy3),
        .err_timeout(err3), .frame_cnt(fc3)
    );

    // Inputs change at the falling edge; outputs are looked at 1 time unit later.
    task automatic drive(input logic [2:0] v, input logic b, input logic d);
        @(negedge clk);
        req_valid = v;
        tx_busy   = b;
        tx_done   = d;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; tx_busy = 1'b0; tx_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_slots();
        for (int k = 0; k < 3; k++) begin
            req_data35[k*35 +: 35] = s35[k];
            req_data32[k*32 +: 32] = s32[k];
        end
    endtask

    task automatic wait_idle(input bit on3, output int n);
        n = 0;
        do begin
            drive(3'b000, 1'b0, 1'b0);
            n++;
        end while ((on3 ? busy3 : busy1) && n < 200);
        if (on3 ? busy3 : busy1) n = -1;
    endtask

    // Answers each tx_start of u1 with tx_done three cycles later, until u1 is idle.
    task automatic finish_cmd(output int starts);
        int since;
        since  = -1;
        starts = 0;
        for (int c = 0; c < 200; c++) begin
            drive(3'b000, 1'b0, since == 2);
            if (start1) begin
                starts++;
                since = 0;
            end else if (since >= 0) begin
                since++;
            end
            if (!busy1) break;
        end
    endtask

    task automatic run_cmd(input logic [2:0] v, output int starts);
        drive(v, 1'b0, 1'b0);
        finish_cmd(starts);
    endtask

    task automatic test_reset();
        do_reset();
        drive(3'b000, 1'b0, 1'b0);
        total++; if (rdy1 !== 3'b000) begin bad++; $display("FAIL rst_ready: got %b want 000", rdy1); end
        total++; if (start1 !== 1'b0) begin bad++; $display("FAIL rst_start: got %b want 0", start1); end
        total++; if (d35_1 !== 35'h0) begin bad++; $display("FAIL rst_d35: got %h want 0", d35_1); end
        total++; if (d32_1 !== 32'h0) begin bad++; $display("FAIL rst_d32: got %h want 0", d32_1); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy1); end
        total++; if (err1 !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err1); end
        total++; if (fc1 !== 16'd0) begin bad++; $display("FAIL rst_fcnt: got %0d want 0", fc1); end
    endtask

    task automatic test_single();
        int nst;
        int n;
        do_reset();
        drive(3'b010, 1'b0, 1'b0);
        total++; if (rdy1 !== 3'b010) begin bad++; $display("FAIL single_ready: got %b want 010", rdy1); end
        drive(3'b010, 1'b0, 1'b0);
        total++; if (rdy1 !== 3'b000) begin bad++; $display("FAIL single_ready_drop: got %b want 000", rdy1); end
        total++; if (start1 !== 1'b1) begin bad++; $display("FAIL single_start: got %b want 1", start1); end
        total++; if (d35_1 !== 35'h5_1234_5678) begin bad++; $display("FAIL single_d35: got %h want 512345678", d35_1); end
        total++; if (d32_1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_d32: got %h want deadbeef", d32_1); end
        nst = 0;
        for (int c = 1; c < 20; c++) begin
            drive(3'b000, 1'b0, 1'b0);
            if (start1) nst++;
        end
        drive(3'b000, 1'b0, 1'b1);
        total++; if (nst !== 0) begin bad++; $display("FAIL single_extra_start: got %0d want 0", nst); end
        wait_idle(1'b0, n);
        total++; if (n !== 11) begin bad++; $display("FAIL single_done_to_idle: got %0d want 11", n); end
        total++; if (fc1 !== 16'd1) begin bad++; $display("FAIL single_fcnt: got %0d want 1", fc1); end
        total++; if (d35_1 !== 35'h5_1234_5678) begin bad++; $display("FAIL single_hold: got %h want 512345678", d35_1); end
    endtask

    task automatic test_fairness();
        int n;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            int w;
            logic [2:0] expg;
            w = 0;
            expg = 3'b000;
            expg[i%3] = 1'b1;
            drive(3'b111, 1'b0, 1'b0);
            while (rdy1 == 3'b000 && w < 30) begin
                drive(3'b111, 1'b0, 1'b0);
                w++;
            end
            total++; if (rdy1 !== expg) begin bad++; $display("FAIL fair_grant_%0d: got %b want %b", i, rdy1, expg); end
            drive(3'b111, 1'b0, 1'b0);
            total++; if (d35_1 !== s35[i%3]) begin bad++; $display("FAIL fair_data_%0d: got %h want %h", i, d35_1, s35[i%3]); end
            drive(3'b111, 1'b0, 1'b1);
        end
        wait_idle(1'b0, n);
        total++; if (fc1 !== 16'd6) begin bad++; $display("FAIL fair_fcnt: got %0d want 6", fc1); end
    endtask

    task automatic test_busy_tx();
        int nst;
        int n;
        do_reset();
        drive(3'b010, 1'b0, 1'b0);
        nst = 0;
        for (int c = 0; c < 7; c++) begin
            drive(3'b000, 1'b1, 1'b0);
            if (start1) nst++;
        end
        total++; if (nst !== 0) begin bad++; $display("FAIL busy_early_start: got %0d want 0", nst); end
        drive(3'b000, 1'b0, 1'b0);
        total++; if (start1 !== 1'b1) begin bad++; $display("FAIL busy_release_start: got %b want 1", start1); end
        drive(3'b000, 1'b0, 1'b1);
        wait_idle(1'b0, n);
        total++; if (n !== 11) begin bad++; $display("FAIL busy_done_to_idle: got %0d want 11", n); end
        total++; if (fc1 !== 16'd1) begin bad++; $display("FAIL busy_fcnt: got %0d want 1", fc1); end
    endtask

    task automatic test_timeout();
        int nst;
        do_reset();
        drive(3'b010, 1'b0, 1'b0);
        drive(3'b000, 1'b0, 1'b0);
        total++; if (start3 !== 1'b1) begin bad++; $display("FAIL to_start: got %b want 1", start3); end
        nst = 1;
        for (int k = 1; k <= 70; k++) begin
            drive(3'b000, 1'b0, 1'b0);
            if (start3) nst++;
            if (k == 49) begin
                total++; if (err3 !== 1'b0) begin bad++; $display("FAIL to_err_early: got %b want 0", err3); end
            end
            if (k == 51) begin
                total++; if (err3 !== 1'b1) begin bad++; $display("FAIL to_err_set: got %b want 1", err3); end
            end
        end
        total++; if (nst !== 1) begin bad++; $display("FAIL to_starts: got %0d want 1", nst); end
        total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL to_idle: got %b want 0", busy3); end
        total++; if (fc3 !== 16'd0) begin bad++; $display("FAIL to_fcnt: got %0d want 0", fc3); end
        total++; if (err3 !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", err3); end
    endtask

    task automatic test_tie();
        int n;
        do_reset();
        drive(3'b010, 1'b0, 1'b0);
        drive(3'b000, 1'b0, 1'b0);
        total++; if (start1 !== 1'b1) begin bad++; $display("FAIL tie_start: got %b want 1", start1); end
        for (int k = 1; k < 50; k++) drive(3'b000, 1'b0, 1'b0);
        drive(3'b000, 1'b0, 1'b1);
        wait_idle(1'b0, n);
        total++; if (err1 !== 1'b0) begin bad++; $display("FAIL tie_err: got %b want 0", err1); end
        total++; if (fc1 !== 16'd1) begin bad++; $display("FAIL tie_fcnt: got %0d want 1", fc1); end
    endtask

    task automatic test_repeat();
        int st [3];
        int dn [3];
        int nst;
        int nd;
        int since;
        logic dnow;
        do_reset();
        st = '{0, 0, 0};
        dn = '{0, 0, 0};
        nst = 0; nd = 0; since = -1;
        drive(3'b010, 1'b0, 1'b0);
        for (int c = 0; c < 300; c++) begin
            dnow = (since == 3);
            drive(3'b000, 1'b0, dnow);
            if (dnow && nd < 3) begin dn[nd] = c; nd++; end
            if (start3) begin
                if (nst < 3) st[nst] = c;
                nst++;
                since = 0;
            end else if (since >= 0) begin
                since++;
            end
            if (!busy3) break;
        end
        total++; if (nst !== 3) begin bad++; $display("FAIL rep_starts: got %0d want 3", nst); end
        total++; if (st[1] - dn[0] !== 11) begin bad++; $display("FAIL rep_gap1: got %0d want 11", st[1] - dn[0]); end
        total++; if (st[2] - dn[1] !== 11) begin bad++; $display("FAIL rep_gap2: got %0d want 11", st[2] - dn[1]); end
        total++; if (fc3 !== 16'd1) begin bad++; $display("FAIL rep_fcnt: got %0d want 1", fc3); end
    endtask

    task automatic test_reset_mid();
        int nst;
        int nb;
        do_reset();
        run_cmd(3'b010, nst);
        total++; if (fc1 !== 16'd1) begin bad++; $display("FAIL rmid_setup_fcnt: got %0d want 1", fc1); end
        drive(3'b010, 1'b0, 1'b0);
        drive(3'b000, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) drive(3'b000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy1); end
        total++; if (fc1 !== 16'd0) begin bad++; $display("FAIL rmid_fcnt: got %0d want 0", fc1); end
        total++; if (d35_1 !== 35'h0) begin bad++; $display("FAIL rmid_d35: got %h want 0", d35_1); end
        total++; if (d32_1 !== 32'h0) begin bad++; $display("FAIL rmid_d32: got %h want 0", d32_1); end
        @(negedge clk);
        rst = 1'b0;
        nst = 0; nb = 0;
        for (int c = 0; c < 30; c++) begin
            drive(3'b000, 1'b0, c == 2);
            if (start1) nst++;
            if (busy1) nb++;
        end
        total++; if (nst !== 0) begin bad++; $display("FAIL rmid_no_start: got %0d want 0", nst); end
        total++; if (nb !== 0) begin bad++; $display("FAIL rmid_stay_idle: got %0d want 0", nb); end
    endtask

    task automatic test_dedup();
        int nst;
        do_reset();
        run_cmd(3'b001, nst);
        total++; if (nst !== 1) begin bad++; $display("FAIL dd_first: got %0d want 1", nst); end
`ifdef IR_SCHED_DEDUP_EN
        begin
            int nb;
            drive(3'b010, 1'b0, 1'b0);
            total++; if (rdy1 !== 3'b010) begin bad++; $display("FAIL dd_dup_ready: got %b want 010", rdy1); end
            nst = 0; nb = 0;
            for (int c = 0; c < 5; c++) begin
                drive(3'b000, 1'b0, 1'b0);
                if (start1) nst++;
                if (busy1) nb++;
            end
            total++; if (nst !== 0) begin bad++; $display("FAIL dd_dup_start: got %0d want 0", nst); end
            total++; if (nb !== 0) begin bad++; $display("FAIL dd_dup_busy: got %0d want 0", nb); end
            total++; if (fc1 !== 16'd1) begin bad++; $display("FAIL dd_dup_fcnt: got %0d want 1", fc1); end
            drive(3'b111, 1'b0, 1'b0);
            total++; if (rdy1 !== 3'b100) begin bad++; $display("FAIL dd_rr_advance: got %b want 100", rdy1); end
            finish_cmd(nst);
            total++; if (nst !== 1) begin bad++; $display("FAIL dd_diff_sent: got %0d want 1", nst); end
            total++; if (fc1 !== 16'd2) begin bad++; $display("FAIL dd_diff_fcnt: got %0d want 2", fc1); end
            do_reset();
            run_cmd(3'b010, nst);
            total++; if (nst !== 1) begin bad++; $display("FAIL dd_after_rst: got %0d want 1", nst); end
        end
`else
        run_cmd(3'b010, nst);
        total++; if (nst !== 1) begin bad++; $display("FAIL dd_resend: got %0d want 1", nst); end
        total++; if (fc1 !== 16'd2) begin bad++; $display("FAIL dd_resend_fcnt: got %0d want 2", fc1); end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got expired want finished");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; req_valid = '0; tx_busy = 1'b0; tx_done = 1'b0;
        req_data35 = '0; req_data32 = '0;
        s35[0] = 35'h0_0000_0011; s32[0] = 32'h0000_0011;
        s35[1] = 35'h5_1234_5678; s32[1] = 32'hDEAD_BEEF;
        s35[2] = 35'h7_0000_0002; s32[2] = 32'h0000_0022;
        load_slots();

        test_reset();
        test_single();
        test_fairness();
        test_busy_tx();
        test_timeout();
        test_tie();
        test_repeat();
        test_reset_mid();

        s35[0] = PWR_OFF_35;      s32[0] = PWR_OFF_32;
        s35[1] = PWR_OFF_35;      s32[1] = PWR_OFF_32;
        s35[2] = 35'h2_AAAA_5555; s32[2] = 32'h1234_5678;
        load_slots();
        test_dedup();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ir_cmd_scheduler.md
Name: ir_cmd_scheduler

Overview:
- Sits between command sources and the air-conditioner IR frame transmitter. Sources include the power key logic, the UART/host command decoder and the timer.
- Arbitrates round-robin among NUM_REQ requesters, each offering a 35-bit + 32-bit AC frame.
- Launches the transmitter, waits for completion with a watchdog, optionally repeats the frame, and enforces a minimum inter-frame gap.
- Clock is 100 MHz.

Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- REPEAT, 1: transmissions per accepted command (1..15).
- GAP_CYCLES, 4000000: idle cycles after every transmission (40 ms).
- TIMEOUT_CYCLES, 25000000: maximum cycles from tx_start to tx_done (250 ms).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester command valid
- req_data35  in  NUM_REQ*35  requester k at bits [k*35 +: 35]
- req_data32  in  NUM_REQ*32  requester k at bits [k*32 +: 32]
- req_ready  out  NUM_REQ  one-hot accept; a transfer occurs when valid&ready
- tx_start  out  1  one-cycle launch pulse to transmitter
- tx_data35  out  35  frame part 1; MSB sent first
- tx_data32  out  32  frame part 2; MSB sent first
- tx_busy  in  1  transmitter not idle
- tx_done  in  1  one-cycle pulse, frame fully sent
- busy  out  1  scheduler not in IDLE
- err_timeout  out  1  sticky watchdog flag; cleared only by rst
- frame_cnt  out  16  completed commands, wraps at 65535->0

Behaviour:
- Reset values: all outputs 0; rr_ptr=0; rep_cnt=0; state IDLE; all counters 0.
- rst asserted mid-operation aborts immediately. No tx_start is issued after release until a new request is accepted.
- req_ready is combinational. It is the one-hot winner only while state==IDLE; otherwise it is 0.
- Winner selection: the first asserted req_valid scanning from rr_ptr upward, mod NUM_REQ.
- States:
  - IDLE: on any req_valid, accept the winner. Latch its data into tx_data35/32, record win_idx, set rep_cnt=0, go LAUNCH. tx_data holds its value until the next accept.
  - LAUNCH: if !tx_busy, pulse tx_start for one cycle, clear the watchdog, go WAIT_DONE. Otherwise stay in LAUNCH.
  - WAIT_DONE:
    - tx_done -> GAP, gap counter loaded with GAP_CYCLES.
    - Watchdog reaching TIMEOUT_CYCLES-1 -> set err_timeout, skip any remaining repeats, go GAP.
    - tx_done and timeout in the same cycle: done wins, err_timeout is not set.
  - GAP: decrement the counter. When it reaches 0:
    - If rep_cnt<REPEAT-1 and there was no timeout: rep_cnt++, go LAUNCH.
    - Otherwise go IDLE, rr_ptr=(win_idx+1) mod NUM_REQ. frame_cnt++ only if no timeout occurred.
- Latency:
  - Accept to tx_start is 1 cycle when tx_busy=0.
  - tx_done to next tx_start or next accept is GAP_CYCLES+1 cycles.
- tx_done outside WAIT_DONE is ignored.
- req_valid deasserting before acceptance is legal; that request is simply not taken.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro IR_SCHED_DEDUP_EN.
- Defined:
  - A last-sent register {valid, data35, data32} is updated on each successful (non-timeout) command completion. It is cleared on rst with valid=0.
  - An accepted request equal to the last-sent frame, with valid=1, is consumed: ready is asserted, it returns to IDLE next cycle, rr_ptr advances, there is no tx_start, and frame_cnt is unchanged.
- Undefined: every accepted command is transmitted and no last-sent register exists.

Decomposition:
- Package ir_sched_pkg:
  - state enum {IDLE, LAUNCH, WAIT_DONE, GAP}
  - constants IR_W35=35, IR_W32=32
  - default timing constants
  - power-off frame constants: 35'b10000010000100000000010000001010010, 32'b00001000000001000000000000000110
- Sub-module ir_rr_arbiter: combinational round-robin pick; inputs valid and rr_ptr; outputs one-hot grant and index.

Test Plan (GAP_CYCLES=10, TIMEOUT_CYCLES=50, REPEAT=1 unless stated):
- Single request:
  - Stimulus: req_valid=3'b010 with data35=35'h5_1234_5678, data32=32'hDEAD_BEEF.
  - Response: req_ready[1] for 1 cycle, tx_start 1 cycle later, tx_data matches. tx_done at +20 -> IDLE 11 cycles later, frame_cnt=1.
- Fairness:
  - Stimulus: all three valid continuously with immediate tx_done.
  - Response: grant order 0,1,2,0,1,2. frame_cnt=6 after six completions.
- Busy transmitter:
  - Stimulus: tx_busy=1 for 7 cycles after accept.
  - Response: tx_start is issued only in the first cycle tx_busy=0.
- Timeout with REPEAT=3:
  - Stimulus: tx_done is never sent.
  - Response: err_timeout=1 at cycle 50 after tx_start, exactly one tx_start, return to IDLE, frame_cnt unchanged. tx_done and timeout in the same cycle -> err_timeout stays 0.
- Repeat and reset:
  - REPEAT=3: 3 tx_start pulses, each separated by done+11 cycles, frame_cnt+1.
  - rst mid-WAIT_DONE: all outputs 0, no further tx_start.
- Dedup (macro defined):
  - Stimulus: the same frame requested twice.
  - Response: second request consumed with no tx_start. A different frame is transmitted. After rst, the same frame is transmitted again.
